// File: rtl/cu_input_packer_if.sv
// cu_input_packer_if
// Bundles the tagged element stream and the three computing-unit FIFO
// write ports (activation, weight, offset) that surround cu_input_packer.
//   master : element source plus FIFO-status side (drives stream, full flags, cu_rst_busy)
//   slave  : the packer (drives ready, packed vectors, write strobes, pulses)
// Signals:
//   cu_rst_busy                      computing-unit FIFO reset in progress
//   s_data / s_tag / s_valid / s_ready  element stream with valid/ready
//   activation, activation_wr_en, activation_full   activation FIFO port
//   weight, weight_wr_en, weight_full               weight FIFO port
//   offset, offset_wr_en, offset_full               offset FIFO port
//   weight_update                    one-cycle weight-update request
//   tag_err                          one-cycle illegal-tag pulse
`ifndef DATA_TYPE_SIZE
`define DATA_TYPE_SIZE 16
`endif

interface cu_input_packer_if #(
  parameter int ACT_LANES  = 16,
  parameter int WGT_LANES  = 16,
  parameter int DATA_WIDTH = `DATA_TYPE_SIZE
);
  logic                              cu_rst_busy;
  logic [DATA_WIDTH-1:0]             s_data;
  logic [1:0]                        s_tag;
  logic                              s_valid;
  logic                              s_ready;
  logic [ACT_LANES*DATA_WIDTH-1:0]   activation;
  logic                              activation_wr_en;
  logic                              activation_full;
  logic [WGT_LANES*DATA_WIDTH-1:0]   weight;
  logic                              weight_wr_en;
  logic                              weight_full;
  logic [WGT_LANES*DATA_WIDTH-1:0]   offset;
  logic                              offset_wr_en;
  logic                              offset_full;
  logic                              weight_update;
  logic                              tag_err;

  modport master (
    output cu_rst_busy, s_data, s_tag, s_valid,
           activation_full, weight_full, offset_full,
    input  s_ready, activation, activation_wr_en, weight, weight_wr_en,
           offset, offset_wr_en, weight_update, tag_err
  );

  modport slave (
    input  cu_rst_busy, s_data, s_tag, s_valid,
           activation_full, weight_full, offset_full,
    output s_ready, activation, activation_wr_en, weight, weight_wr_en,
           offset, offset_wr_en, weight_update, tag_err
  );
endinterface

// File: rtl/cu_input_packer.sv
// cu_input_packer
// Packs a tagged element stream (one element per cycle) into full lane
// vectors and writes each into the activation, weight or offset FIFO of
// the computing unit. After every ACT_LANES weight writes a one-cycle
// weight-update request is issued.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : cu_input_packer_if.slave (stream in, FIFO write ports out)
`ifndef DATA_TYPE_SIZE
`define DATA_TYPE_SIZE 16
`endif

module cu_input_packer #(
  parameter int ACT_LANES  = 16,
  parameter int WGT_LANES  = 16,
  parameter int DATA_WIDTH = `DATA_TYPE_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cu_input_packer_if.slave      bus
);

  localparam int MAXL = (ACT_LANES > WGT_LANES) ? ACT_LANES : WGT_LANES;
  localparam int LW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam int RW   = (ACT_LANES > 1) ? $clog2(ACT_LANES) : 1;
  localparam logic [LW-1:0] ACT_LAST  = LW'(ACT_LANES - 1);
  localparam logic [LW-1:0] WGT_LAST  = LW'(WGT_LANES - 1);
  localparam logic [RW-1:0] WROW_LAST = RW'(ACT_LANES - 1);

  typedef enum logic {FILL, WRITE} state_t;

  state_t                             state_q, state_d;
  logic [LW-1:0]                      lane_q, lane_d;
  logic [1:0]                         cur_tag_q, cur_tag_d;
  logic [RW-1:0]                      wrow_q, wrow_d;
  logic [MAXL-1:0][DATA_WIDTH-1:0]    pack_q, pack_d;
  logic                               tag_err_q, tag_err_d;
  logic                               wupd_q, wupd_d;
  // Holds s_ready low while reset is asserted and for the first edge after.
  logic                               run_q;

  logic          s_ready;
  logic          act_we, wgt_we, off_we;
  logic [1:0]    eff_tag;
  logic [LW-1:0] vec_last;
  logic          tgt_full;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= FILL;
      lane_q    <= '0;
      cur_tag_q <= '0;
      wrow_q    <= '0;
      pack_q    <= '0;
      tag_err_q <= 1'b0;
      wupd_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      cur_tag_q <= cur_tag_d;
      wrow_q    <= wrow_d;
      pack_q    <= pack_d;
      tag_err_q <= tag_err_d;
      wupd_q    <= wupd_d;
      run_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    cur_tag_d = cur_tag_q;
    wrow_d    = wrow_q;
    pack_d    = pack_q;
    tag_err_d = 1'b0;
    wupd_d    = 1'b0;
    s_ready   = 1'b0;
    act_we    = 1'b0;
    wgt_we    = 1'b0;
    off_we    = 1'b0;

    // The tag is only meaningful on lane 0; later lanes follow the latched tag.
    eff_tag  = (lane_q == '0) ? bus.s_tag : cur_tag_q;
    vec_last = (eff_tag == 2'd0) ? ACT_LAST : WGT_LAST;

    case (cur_tag_q)
      2'd0:    tgt_full = bus.activation_full;
      2'd1:    tgt_full = bus.weight_full;
      default: tgt_full = bus.offset_full;
    endcase

    case (state_q)
      FILL: begin
        s_ready = run_q & ~bus.cu_rst_busy;
        if (s_ready && bus.s_valid) begin
          if (lane_q == '0 && bus.s_tag == 2'd3) begin
            tag_err_d = 1'b1;
          end else begin
            pack_d[lane_q] = bus.s_data;
            cur_tag_d      = eff_tag;
            if (lane_q == vec_last) begin
              lane_d  = '0;
              state_d = WRITE;
            end else begin
              lane_d = lane_q + LW'(1);
            end
          end
        end
      end
      WRITE: begin
        if (!tgt_full && !bus.cu_rst_busy) begin
          state_d = FILL;
          case (cur_tag_q)
            2'd0: act_we = 1'b1;
            2'd1: begin
              wgt_we = 1'b1;
              if (wrow_q == WROW_LAST) begin
                wrow_d = '0;
                wupd_d = 1'b1;
              end else begin
                wrow_d = wrow_q + RW'(1);
              end
            end
            default: off_we = 1'b1;
          endcase
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.s_ready          = s_ready;
  assign bus.activation       = pack_q[ACT_LANES-1:0];
  assign bus.weight           = pack_q[WGT_LANES-1:0];
  assign bus.offset           = pack_q[WGT_LANES-1:0];
  assign bus.activation_wr_en = act_we;
  assign bus.weight_wr_en     = wgt_we;
  assign bus.offset_wr_en     = off_we;
  assign bus.weight_update    = wupd_q;
  assign bus.tag_err          = tag_err_q;

endmodule

// File: tb/tb_cu_input_packer.sv
// tb_cu_input_packer
// Directed bench for cu_input_packer with 16/16 lanes of 16-bit data.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
module tb_cu_input_packer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cu_input_packer_if #(.ACT_LANES(16), .WGT_LANES(16), .DATA_WIDTH(16)) bus ();

  cu_input_packer #(.ACT_LANES(16), .WGT_LANES(16), .DATA_WIDTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] exp_vec(input logic [15:0] base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = base + 16'(i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one element and hold it until it is accepted (bounded).
  task automatic push(input logic [15:0] d, input logic [1:0] t);
    int waits;
    waits = 0;
    bus.s_data  = d;
    bus.s_tag   = t;
    bus.s_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk("push_ready", bus.s_ready, 1'b1);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] base, input logic [1:0] t0, input logic [1:0] t);
    for (int i = 0; i < 16; i++) push(base + 16'(i), (i == 0) ? t0 : t);
  endtask

  // Checks the strobe cycle: exactly one write enable, matching data, ready low.
  task automatic expect_write(input string tag, input int which, input logic [15:0] base);
    @(negedge clk);
    chk({tag, "_act_we"}, bus.activation_wr_en, 1'(which == 0));
    chk({tag, "_wgt_we"}, bus.weight_wr_en, 1'(which == 1));
    chk({tag, "_off_we"}, bus.offset_wr_en, 1'(which == 2));
    chk({tag, "_ready"}, bus.s_ready, 1'b0);
    case (which)
      0:       chk({tag, "_act_data"}, bus.activation, exp_vec(base));
      1:       chk({tag, "_wgt_data"}, bus.weight, exp_vec(base));
      default: chk({tag, "_off_data"}, bus.offset, exp_vec(base));
    endcase
    tick();
  endtask

  task automatic weight_vec(input string tag, input logic [15:0] base, input logic exp_upd);
    send_vec(base, 2'd1, 2'd1);
    expect_write(tag, 1, base);
    @(negedge clk);
    chk({tag, "_update"}, bus.weight_update, exp_upd);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, bus.s_ready, 1'b0);
    chk({tag, "_act"}, bus.activation, '0);
    chk({tag, "_wgt"}, bus.weight, '0);
    chk({tag, "_off"}, bus.offset, '0);
    chk({tag, "_we"}, {bus.activation_wr_en, bus.weight_wr_en, bus.offset_wr_en}, '0);
    chk({tag, "_pulses"}, {bus.weight_update, bus.tag_err}, '0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cu_rst_busy     = 1'b0;
    bus.s_data          = '0;
    bus.s_tag           = '0;
    bus.s_valid         = 1'b0;
    bus.activation_full = 1'b0;
    bus.weight_full     = 1'b0;
    bus.offset_full     = 1'b0;

    // Reset state
    #2;
    chk_all_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Activation fill: values 1..16, strobe in the cycle after the last accept
    send_vec(16'h0001, 2'd0, 2'd0);
    expect_write("act", 0, 16'h0001);
    @(negedge clk);
    chk("act_after_ready", bus.s_ready, 1'b1);
    chk("act_after_we", bus.activation_wr_en, 1'b0);
    tick();

    // cu_rst_busy mid-vector pauses accepts, and also holds the strobe off
    for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i), 2'd0);
    bus.cu_rst_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("busy_ready", bus.s_ready, 1'b0);
      tick();
    end
    bus.cu_rst_busy = 1'b0;
    for (int i = 5; i < 16; i++) push(16'h0200 + 16'(i), 2'd0);
    bus.cu_rst_busy = 1'b1;
    @(negedge clk);
    chk("busy_write_held", bus.activation_wr_en, 1'b0);
    tick();
    bus.cu_rst_busy = 1'b0;
    expect_write("busy", 0, 16'h0200);

    // Backpressure: weight_full high for 5 cycles in WRITE
    bus.weight_full = 1'b1;
    send_vec(16'h0100, 2'd1, 2'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_we", bus.weight_wr_en, 1'b0);
      chk("bp_ready", bus.s_ready, 1'b0);
      chk("bp_data", bus.weight, exp_vec(16'h0100));
      tick();
    end
    bus.weight_full = 1'b0;
    expect_write("bp", 1, 16'h0100);
    @(negedge clk);
    chk("bp_update", bus.weight_update, 1'b0);
    tick();

    // Weight tile: vectors 2..17; only the 16th raises weight_update
    for (int k = 2; k <= 17; k++)
      weight_vec("tile", 16'h1000 + 16'(k * 16), 1'(k == 16));

    // Illegal tag dropped, then an offset vector
    push(16'hDEAD, 2'd3);
    @(negedge clk);
    chk("ill_tag_err", bus.tag_err, 1'b1);
    chk("ill_we", {bus.activation_wr_en, bus.weight_wr_en, bus.offset_wr_en}, '0);
    chk("ill_ready", bus.s_ready, 1'b1);
    tick();
    @(negedge clk);
    chk("ill_tag_err_once", bus.tag_err, 1'b0);
    tick();
    send_vec(16'h0300, 2'd2, 2'd2);
    expect_write("off", 2, 16'h0300);

    // Tag changes after lane 0 are ignored
    send_vec(16'h0400, 2'd0, 2'd1);
    expect_write("mix", 0, 16'h0400);

    // Reset mid-vector (weight row counter is currently 1)
    for (int i = 0; i < 7; i++) push(16'h0AA0 + 16'(i), 2'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    send_vec(16'h0500, 2'd0, 2'd0);
    expect_write("rst", 0, 16'h0500);

    // Row counter restarted by reset: update only on the 16th weight vector
    for (int k = 0; k < 16; k++)
      weight_vec("wrow", 16'h2000 + 16'(k * 16), 1'(k == 15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
